// File: rtl/sayac_pkt.sv
// Shared constants for the counter pipeline receiver: field widths and the
// bit layout of a buffered entry {yon, miktar, sonuc}.
package sayac_pkt;

  localparam int MIKTAR_GENISLIK          = 3;
  localparam int VERI_GENISLIK_VARSAYILAN = 8;
  localparam int TOPLAM_GENISLIK          = 16;
  localparam int SONUC_LSB                = 0;

  function automatic int girdi_genislik(input int veri_genislik);
    return veri_genislik + MIKTAR_GENISLIK + 1;
  endfunction

  function automatic int miktar_lsb(input int veri_genislik);
    return SONUC_LSB + veri_genislik;
  endfunction

  function automatic int yon_bit(input int veri_genislik);
    return miktar_lsb(veri_genislik) + MIKTAR_GENISLIK;
  endfunction

  localparam int GIRDI_GENISLIK = girdi_genislik(VERI_GENISLIK_VARSAYILAN);

endpackage

// File: rtl/alici_fifo.sv
// First-word-fall-through FIFO with a separate occupancy counter; a push into
// a full FIFO is accepted only when a pop frees the slot in the same cycle.
module alici_fifo
  import sayac_pkt::*;
#(
  parameter int DERINLIK = 4,
  parameter int GENISLIK = GIRDI_GENISLIK
) (
  input  logic                        saat,
  input  logic                        reset,
  input  logic                        yaz_i,
  input  logic [GENISLIK-1:0]         girdi_i,
  input  logic                        oku_i,
  output logic [GENISLIK-1:0]         bas_o,
  output logic                        kabul_o,
  output logic                        bos_o,
  output logic                        dolu_o,
  output logic [$clog2(DERINLIK):0]   sayi_o
);

  localparam int PTR_W  = $clog2(DERINLIK);
  localparam int SAYI_W = PTR_W + 1;

  logic [GENISLIK-1:0] mem_q [DERINLIK];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [SAYI_W-1:0]   sayi_q, sayi_d;
  logic                pop, push;

  assign bos_o   = (sayi_q == '0);
  assign dolu_o  = (sayi_q == SAYI_W'(DERINLIK));
  assign pop     = oku_i && !bos_o;
  assign push    = yaz_i && (!dolu_o || pop);
  assign kabul_o = push;
  assign sayi_o  = sayi_q;
  assign bas_o   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sayi_d   = sayi_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      sayi_d = sayi_q + 1'b1;
    else if (pop && !push) sayi_d = sayi_q - 1'b1;
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sayi_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sayi_q   <= sayi_d;
    end
  end

  // NOTE: storage has no reset; emptiness comes from sayi_q and the top zeroes
  // the outputs, so stale contents are never visible.
  always_ff @(posedge saat) begin
    if (push) mem_q[wr_ptr_q] <= girdi_i;
  end

endmodule

// File: rtl/sayac_sonuc_alici.sv
// Receiver for counter pipeline results: buffers {yon, miktar, sonuc} entries,
// flags sticky overflow, optional running sum under SAYAC_ALICI_TOPLAM_EN.
module sayac_sonuc_alici
  import sayac_pkt::*;
#(
  parameter int DERINLIK      = 4,
  parameter int VERI_GENISLIK = VERI_GENISLIK_VARSAYILAN
) (
  input  logic                        saat,
  input  logic                        reset,
  input  logic                        hazir,
  input  logic [VERI_GENISLIK-1:0]    sonuc,
  input  logic                        yon,
  input  logic [MIKTAR_GENISLIK-1:0]  miktar,
  input  logic                        oku,
  output logic                        gecerli,
  output logic [VERI_GENISLIK-1:0]    cikis_veri,
  output logic                        cikis_yon,
  output logic [MIKTAR_GENISLIK-1:0]  cikis_miktar,
  output logic                        dolu,
  output logic [$clog2(DERINLIK):0]   sayi,
  output logic                        tasma,
  output logic [TOPLAM_GENISLIK-1:0]  toplam
);

  localparam int GW    = girdi_genislik(VERI_GENISLIK);
  localparam int M_LSB = miktar_lsb(VERI_GENISLIK);
  localparam int Y_BIT = yon_bit(VERI_GENISLIK);

  logic [GW-1:0] girdi, bas, bas_gorunen;
  logic          kabul, bos;
  logic          tasma_q, tasma_d;

  assign girdi = {yon, miktar, sonuc};

  alici_fifo #(
    .DERINLIK (DERINLIK),
    .GENISLIK (GW)
  ) u_fifo (
    .saat    (saat),
    .reset   (reset),
    .yaz_i   (hazir),
    .girdi_i (girdi),
    .oku_i   (oku),
    .bas_o   (bas),
    .kabul_o (kabul),
    .bos_o   (bos),
    .dolu_o  (dolu),
    .sayi_o  (sayi)
  );

  assign gecerli      = !bos;
  assign bas_gorunen  = gecerli ? bas : '0;
  assign cikis_veri   = bas_gorunen[M_LSB-1:SONUC_LSB];
  assign cikis_miktar = bas_gorunen[Y_BIT-1:M_LSB];
  assign cikis_yon    = bas_gorunen[Y_BIT];

  // A pulse the FIFO could not take is lost for good, hence sticky.
  always_comb begin
    tasma_d = tasma_q;
    if (hazir && !kabul) tasma_d = 1'b1;
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) tasma_q <= 1'b0;
    else       tasma_q <= tasma_d;
  end

  assign tasma = tasma_q;

`ifdef SAYAC_ALICI_TOPLAM_EN
  logic [TOPLAM_GENISLIK-1:0] toplam_q, toplam_d;

  always_comb begin
    toplam_d = toplam_q;
    if (kabul) toplam_d = toplam_q + TOPLAM_GENISLIK'(sonuc);
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) toplam_q <= '0;
    else       toplam_q <= toplam_d;
  end

  assign toplam = toplam_q;
`else
  assign toplam = '0;
`endif

endmodule

// File: tb/tb_sayac_sonuc_alici.sv
// Directed bench for sayac_sonuc_alici; expected sums follow SAYAC_ALICI_TOPLAM_EN.
module tb_sayac_sonuc_alici;

  logic        saat = 1'b0;
  logic        reset = 1'b0;
  logic        hazir = 1'b0;
  logic [7:0]  sonuc = '0;
  logic        yon = 1'b0;
  logic [2:0]  miktar = '0;
  logic        oku = 1'b0;
  logic        gecerli;
  logic [7:0]  cikis_veri;
  logic        cikis_yon;
  logic [2:0]  cikis_miktar;
  logic        dolu;
  logic [2:0]  sayi;
  logic        tasma;
  logic [15:0] toplam;

  int n_checks = 0;
  int n_fail   = 0;

  sayac_sonuc_alici #(.DERINLIK(4), .VERI_GENISLIK(8)) dut (
    .saat         (saat),
    .reset        (reset),
    .hazir        (hazir),
    .sonuc        (sonuc),
    .yon          (yon),
    .miktar       (miktar),
    .oku          (oku),
    .gecerli      (gecerli),
    .cikis_veri   (cikis_veri),
    .cikis_yon    (cikis_yon),
    .cikis_miktar (cikis_miktar),
    .dolu         (dolu),
    .sayi         (sayi),
    .tasma        (tasma),
    .toplam       (toplam)
  );

  always #5 saat = ~saat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beklenen_toplam(input logic [31:0] deger);
`ifdef SAYAC_ALICI_TOPLAM_EN
    return deger;
`else
    return 32'(deger - deger);
`endif
  endfunction

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hazir = 1'b0;
    oku   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] v, input logic y, input logic [2:0] m, input logic rd);
    hazir = 1'b1; sonuc = v; yon = y; miktar = m; oku = rd;
    tick();
    hazir = 1'b0; oku = 1'b0;
  endtask

  task automatic pop();
    oku = 1'b1;
    tick();
    oku = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [7:0] exp_v);
    check({tag, "_gecerli"}, 32'(gecerli), 32'd1);
    check({tag, "_veri"}, 32'(cikis_veri), 32'(exp_v));
    pop();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_gecerli", 32'(gecerli), 0);
    check("rst_dolu", 32'(dolu), 0);
    check("rst_sayi", 32'(sayi), 0);
    check("rst_tasma", 32'(tasma), 0);
    check("rst_toplam", 32'(toplam), 0);
    check("rst_veri", 32'(cikis_veri), 0);

    // Single result
    push(8'h2A, 1'b1, 3'd3, 1'b0);
    check("tek_gecerli", 32'(gecerli), 1);
    check("tek_veri", 32'(cikis_veri), 32'h2A);
    check("tek_yon", 32'(cikis_yon), 1);
    check("tek_miktar", 32'(cikis_miktar), 3);
    check("tek_sayi", 32'(sayi), 1);
    pop();
    check("tek_bos_gecerli", 32'(gecerli), 0);
    check("tek_bos_veri", 32'(cikis_veri), 0);
    check("tek_bos_yon", 32'(cikis_yon), 0);
    check("tek_bos_miktar", 32'(cikis_miktar), 0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i), i[0], 3'(i), 1'b0);
    check("dolu_once_tasma", 32'(tasma), 0);
    check("dolu_flag", 32'(dolu), 1);
    push(8'd5, 1'b0, 3'd5, 1'b0);
    check("tasma_dolu", 32'(dolu), 1);
    check("tasma_sayi", 32'(sayi), 4);
    check("tasma_flag", 32'(tasma), 1);
    check("tasma_toplam", 32'(toplam), beklenen_toplam(10));
    for (int i = 1; i <= 4; i++) begin
      check("tasma_drain_miktar", 32'(cikis_miktar), 32'(i));
      check("tasma_drain_yon", 32'(cikis_yon), 32'(i % 2));
      drain_expect("tasma_drain", 8'(i));
    end
    check("tasma_son_gecerli", 32'(gecerli), 0);
    check("tasma_yapiskan", 32'(tasma), 1);

    // Full plus simultaneous read/write
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0, 3'd1, 1'b0);
    push(8'd9, 1'b1, 3'd7, 1'b1);
    check("eszaman_tasma", 32'(tasma), 0);
    check("eszaman_sayi", 32'(sayi), 4);
    check("eszaman_dolu", 32'(dolu), 1);
    check("eszaman_toplam", 32'(toplam), beklenen_toplam(19));
    drain_expect("eszaman_drain", 8'd2);
    drain_expect("eszaman_drain", 8'd3);
    // A pop alone from a non-full FIFO decrements sayi
    check("eszaman_sayi_pop", 32'(sayi), 2);
    drain_expect("eszaman_drain", 8'd4);
    check("eszaman_dokuz_yon", 32'(cikis_yon), 1);
    check("eszaman_dokuz_miktar", 32'(cikis_miktar), 7);
    drain_expect("eszaman_drain", 8'd9);
    check("eszaman_bos", 32'(gecerli), 0);

    // Read while empty, then push with oku still high
    do_reset();
    oku = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bos_oku_sayi", 32'(sayi), 0);
    end
    push(8'd7, 1'b0, 3'd2, 1'b1);
    check("bos_oku_veri", 32'(cikis_veri), 7);
    check("bos_oku_sayi1", 32'(sayi), 1);
    push(8'd8, 1'b0, 3'd2, 1'b0);
    drain_expect("bos_oku_drain", 8'd7);
    drain_expect("bos_oku_drain", 8'd8);
    check("bos_oku_son", 32'(sayi), 0);

    // Asynchronous reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) push(8'(i + 16), 1'b0, 3'd0, 1'b0);
    pop();
    check("arst_once_sayi", 32'(sayi), 3);
    check("arst_once_tasma", 32'(tasma), 1);
    @(posedge saat);
    #3;
    reset = 1'b1;
    #1;
    check("arst_gecerli", 32'(gecerli), 0);
    check("arst_sayi", 32'(sayi), 0);
    check("arst_tasma", 32'(tasma), 0);
    check("arst_toplam", 32'(toplam), 0);
    check("arst_veri", 32'(cikis_veri), 0);
    #2;
    reset = 1'b0;
    tick();
    check("arst_sonra_sayi", 32'(sayi), 0);

    // Accumulator
    do_reset();
    push(8'd200, 1'b0, 3'd0, 1'b0);
    push(8'd100, 1'b0, 3'd0, 1'b1);
    push(8'hFF, 1'b0, 3'd0, 1'b1);
    check("toplam_555", 32'(toplam), beklenen_toplam(555));
    for (int i = 0; i < 300; i++) push(8'hFF, 1'b0, 3'd0, 1'b1);
    check("toplam_sarma", 32'(toplam), beklenen_toplam(11519));
    check("toplam_sayi", 32'(sayi), 1);
    check("toplam_tasma", 32'(tasma), 0);
    pop();
    check("toplam_pop_etkisiz", 32'(toplam), beklenen_toplam(11519));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sayac_sonuc_alici.md
Name: sayac_sonuc_alici

Overview:
- Receiving end of the two-stage counter pipeline.
- Captures every completed result: a one-cycle `hazir` pulse with `sonuc`, `yon` and `miktar`. Buffers the results in a small FIFO and presents them to a downstream reader through a valid/read handshake.
- Sits directly after the pipeline's `bitti`/`sayac2_sonuc` outputs, so pulses that arrive while the consumer is stalled are not lost.

Parameters:
- DERINLIK, 4, number of FIFO entries; power of two, at least 2.
- VERI_GENISLIK, 8, width of `sonuc` and `cikis_veri`.

Ports:
- saat  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- hazir  input  1  one-cycle pulse: a result is valid this cycle.
- sonuc  input  VERI_GENISLIK  result value, sampled when `hazir`=1.
- yon  input  1  counting direction that produced the result, sampled with `hazir`.
- miktar  input  3  step amount that produced the result, sampled with `hazir`.
- oku  input  1  reader pops the head entry this cycle.
- gecerli  output  1  FIFO non-empty; head entry is on the `cikis_*` ports.
- cikis_veri  output  VERI_GENISLIK  head entry value.
- cikis_yon  output  1  head entry direction.
- cikis_miktar  output  3  head entry amount.
- dolu  output  1  FIFO full.
- sayi  output  $clog2(DERINLIK)+1  current occupancy.
- tasma  output  1  sticky overflow flag.
- toplam  output  16  running sum of accepted results (see Optional Feature).

Behaviour:
- **Reset:** `reset`=1 asynchronously clears read/write pointers, `sayi`, `tasma` and `toplam`. Outputs read `gecerli`=0, `dolu`=0, `sayi`=0, `tasma`=0, `toplam`=0, `cikis_*`=0.
  - Reset mid-operation discards all buffered entries immediately.
  - A `hazir` pulse coincident with reset is dropped.
- **Storage:** each entry is packed as {yon, miktar, sonuc}, VERI_GENISLIK+4 bits.
- **Read side:** first-word-fall-through.
  - `cikis_*` reflects the head entry whenever `gecerli`=1. It is zero when the FIFO is empty (muxed, not stale).
  - With `gecerli`=1, `oku`=1 pops the head at the clock edge; the next entry is visible in the following cycle.
  - `oku` while empty is ignored: no pointer change, no error.
- **Write side:** `hazir`=1 with `dolu`=0 writes the entry at the write pointer and increments the pointer.
- **Write while full:**
  - `hazir`=1 with `dolu`=1 and `oku`=0: the entry is dropped and `tasma` is set.
  - `tasma` stays set until reset.
  - Stored contents are unchanged.
- **Simultaneous read and write:**
  - `hazir`=1 and `oku`=1 with the FIFO non-empty: the pop and the push both happen and `sayi` is unchanged.
  - This holds when full: the pop frees a slot, the push is accepted and `tasma` is not set.
  - When empty, `oku` is ignored and the push proceeds; the entry becomes visible the next cycle.
- **Pointers:** log2(DERINLIK) bits each, wrapping naturally modulo DERINLIK.
  - `sayi` is a separate counter: +1 on accepted push only, −1 on pop only, unchanged on both or neither.
  - `dolu` = (`sayi`==DERINLIK); `gecerli` = (`sayi`!=0).
- **Latency:** `hazir` in cycle N gives `gecerli`=1 in cycle N+1 when the FIFO was empty.
- **FSM:** none beyond the occupancy counter. The block is fully streaming, with no back-pressure on `hazir`; that is the reason for the sticky `tasma`.

Optional Feature:
- Macro `SAYAC_ALICI_TOPLAM_EN`.
- **Defined:** a 16-bit register `toplam` adds zero-extended `sonuc` on every accepted push.
  - It wraps modulo 2^16, is cleared by reset, and is not affected by pops.
  - Dropped (overflowed) results are not added.
- **Undefined:** the adder and register are not generated and `toplam` is tied to 0.

Decomposition:
- **Shared package/header `sayac_pkt`:**
  - MIKTAR_GENISLIK=3.
  - VERI_GENISLIK default 8.
  - Entry width constant GIRDI_GENISLIK = VERI_GENISLIK+4.
  - Field offsets for the packed entry (sonuc LSBs, then miktar, then yon MSB).
- **One sub-module `alici_fifo`:** storage array, pointers and the `sayi` counter, with push/pop/full/empty.
  - The top level adds entry packing/unpacking, overflow detection, output zeroing and the optional `toplam` accumulator.

Test Plan:
- **Single result:** reset, then one pulse `hazir` with `sonuc`=8'h2A, `yon`=1, `miktar`=3 → next cycle `gecerli`=1, `cikis_veri`=2A, `cikis_yon`=1, `cikis_miktar`=3, `sayi`=1; `oku`=1 → next cycle `gecerli`=0, `cikis_veri`=0.
- **Fill and overflow:** 4 pulses with values 1,2,3,4, then a 5th with value 5 and no `oku` → `dolu`=1, `sayi`=4, `tasma`=1; reads return 1,2,3,4 in order and 5 never appears.
- **Full plus simultaneous read/write:** full FIFO holding 1..4, then `hazir` (value 9) and `oku` in the same cycle → `tasma` stays 0, `sayi`=4, drain order 2,3,4,9.
- **Read while empty:** `oku` held high with the FIFO empty for 3 cycles, then one `hazir` with value 7 → pointers are not corrupted and the next cycle shows `cikis_veri`=7, `sayi`=1.
- **Reset mid-operation:** 3 entries buffered and `tasma` set, assert `reset` asynchronously mid-cycle → `gecerli`, `sayi`, `tasma` and `toplam` are all 0 immediately, without waiting for a clock edge.
- **Accumulator (`SAYAC_ALICI_TOPLAM_EN` defined):** push 200, 100, 8'hFF → `toplam`=555. Push 300 more values of 8'hFF → `toplam` wraps (555+76500) mod 65536 = 11519. Without the macro `toplam` is 0 throughout.
